// File: rtl/spi_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the SPI transaction arbiter.
// Field offsets describe the per-requester {cpol, cpha, cs[1:0]} config nibble.
package spi_ctrl_pkg;

  localparam int NUM_REQ   = 4;
  localparam int LEN_W     = 4;
  localparam int CFG_W     = 4;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = LEN_W + 1;
  localparam int LEN_MAX   = 1 << LEN_W;
  localparam int CFG_CPOL  = 3;
  localparam int CFG_CPHA  = 2;
  localparam int CFG_CS_HI = 1;
  localparam int CFG_CS_LO = 0;
  localparam int CS_W      = CFG_CS_HI - CFG_CS_LO + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic            cpol;
    logic            cpha;
    logic [CS_W-1:0] cs;
  } cfg_t;

  // A zero length field encodes the maximum transfer size.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [LEN_W-1:0] len);
    return (len == '0) ? CNT_W'(LEN_MAX) : {1'b0, len};
  endfunction

  function automatic cfg_t cfg_unpack(input logic [CFG_W-1:0] field);
    cfg_t c;
    c.cpol = field[CFG_CPOL];
    c.cpha = field[CFG_CPHA];
    c.cs   = field[CFG_CS_HI:CFG_CS_LO];
    return c;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Byte-engine side of the arbiter: MOSI byte port, MISO receive port and
// the SPI mode/chip-select configuration latched per transaction.
interface spi_txn_arbiter_if;
  import spi_ctrl_pkg::*;

  logic [7:0]      o_mosi_data;
  logic            o_mosi_valid;
  logic            i_mosi_ready;
  logic            i_miso_valid;
  logic [7:0]      i_miso_data;
  logic            o_cpol;
  logic            o_cpha;
  logic [CS_W-1:0] o_cs;

  modport master (
    output o_mosi_data, o_mosi_valid, o_cpol, o_cpha, o_cs,
    input  i_mosi_ready, i_miso_valid, i_miso_data
  );

  modport slave (
    input  o_mosi_data, o_mosi_valid, o_cpol, o_cpha, o_cs,
    output i_mosi_ready, i_miso_valid, i_miso_data
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr wins.
// Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
module spi_rr_arbiter
  import spi_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_pick;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign w_rot[gi] = i_req[PTR_W'(gi) + i_ptr];
  end

  assign w_pick = w_rot & (~w_rot + NUM_REQ'(1));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unrot
    assign o_gnt[gi] = w_pick[PTR_W'(gi) - i_ptr];
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that hands the SPI byte engine to one requester for a
// whole multi-byte transaction, pacing bytes through the engine handshake.
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
  input  logic [NUM_REQ*CFG_W-1:0] i_req_cfg,
  output logic [NUM_REQ-1:0]       o_gnt,
  input  logic [7:0]               i_tx_data,
  input  logic                     i_tx_valid,
  output logic                     o_tx_ready,
  output logic [7:0]               o_rx_data,
  output logic                     o_rx_valid,
  output logic                     o_done,
  spi_txn_arbiter_if.master        eng
);

  state_e             r_state;
  state_e             w_state_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [CNT_W-1:0]   r_cnt;
  cfg_t               r_cfg;
  logic [7:0]         r_mosi_data;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_miso_prev;
  logic               r_got;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [LEN_W-1:0]   w_len_terms [NUM_REQ];
  logic [CFG_W-1:0]   w_cfg_terms [NUM_REQ];
  logic [LEN_W-1:0]   w_win_len;
  logic [CFG_W-1:0]   w_win_cfg;
  logic               w_start;
  logic               w_accept;
  logic               w_miso_rise;
  logic               w_capture;
  logic               w_leave;

  spi_rr_arbiter u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
    assign w_len_terms[gi] = i_req_len[gi*LEN_W +: LEN_W] & {LEN_W{w_arb_gnt[gi]}};
    assign w_cfg_terms[gi] = i_req_cfg[gi*CFG_W +: CFG_W] & {CFG_W{w_arb_gnt[gi]}};
  end

  always_comb begin
    w_win_len = '0;
    w_win_cfg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_len = w_win_len | w_len_terms[i];
      w_win_cfg = w_win_cfg | w_cfg_terms[i];
    end
  end

  assign w_start     = (r_state == ST_IDLE) && (|i_req) && eng.i_mosi_ready;
  assign w_accept    = (r_state == ST_LOAD) && i_tx_valid;
  assign w_miso_rise = eng.i_miso_valid && !r_miso_prev;
  // Only the first rising edge within a byte counts; the rest are ignored.
  assign w_capture   = (r_state == ST_WAIT_DONE) && w_miso_rise && !r_got;
  assign w_leave     = (r_state == ST_WAIT_DONE) && (r_got || w_miso_rise) && eng.i_mosi_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_tx_ready   = 1'b0;
    o_done       = 1'b0;
    eng.o_mosi_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_tx_ready = 1'b1;
        if (i_tx_valid) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        eng.o_mosi_valid = 1'b1;
        w_state_next     = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!eng.i_mosi_ready) w_state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_leave) w_state_next = (r_cnt == CNT_W'(1)) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_cfg       <= '0;
      r_mosi_data <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_miso_prev <= 1'b0;
      r_got       <= 1'b0;
    end else begin
      r_miso_prev <= eng.i_miso_valid;
      r_rx_valid  <= w_capture;
      if (w_capture) begin
        r_rx_data <= eng.i_miso_data;
        r_got     <= 1'b1;
      end
      // Grant, length and config are snapshotted together; later input changes are ignored.
      if (w_start) begin
        r_gnt <= w_arb_gnt;
        r_cnt <= len_to_count(w_win_len);
        r_cfg <= cfg_unpack(w_win_cfg);
        r_ptr <= onehot_to_idx(w_arb_gnt) + PTR_W'(1);
      end else if (r_state == ST_DONE) begin
        r_gnt <= '0;
      end
      if (w_accept) begin
        r_mosi_data <= i_tx_data;
      end
      if (w_leave) begin
        r_got <= 1'b0;
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_gnt           = r_gnt;
  assign o_rx_data       = r_rx_data;
  assign o_rx_valid      = r_rx_valid;
  assign eng.o_mosi_data = r_mosi_data;
  assign eng.o_cpol      = r_cfg.cpol;
  assign eng.o_cpha      = r_cfg.cpha;
  assign eng.o_cs        = r_cfg.cs;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomised scoreboard bench: a loopback byte-engine model, a requester driver,
// and a monitor checking each byte and transaction end against a queue.
module tb_spi_txn_arbiter;
  import spi_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  i_req;
  logic [15:0] i_req_len;
  logic [15:0] i_req_cfg;
  logic [3:0]  o_gnt;
  logic [7:0]  i_tx_data;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid;
  logic        o_done;

  spi_txn_arbiter_if eng ();

  spi_txn_arbiter dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_req      (i_req),
    .i_req_len  (i_req_len),
    .i_req_cfg  (i_req_cfg),
    .o_gnt      (o_gnt),
    .i_tx_data  (i_tx_data),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .o_done     (o_done),
    .eng        (eng)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int       k;
    int       len;
    logic [3:0] cfg;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] plan_data [4][16];
  int         model_ptr = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_ignore = 1'b0;
  bit         hold_mode = 1'b0;
  int         hold_left = 0;
  int         stretch_cfg = 1;

  // Byte engine: goes busy on a MOSI byte, later echoes it on MISO for
  // stretch_cfg cycles and reports idle again on the last MISO cycle.
  int         eng_phase;
  int         busy_cnt;
  int         str_cnt;
  logic [7:0] eng_byte;

  always @(posedge clk) begin
    if (!rstn) begin
      eng.i_mosi_ready <= 1'b1;
      eng.i_miso_valid <= 1'b0;
      eng.i_miso_data  <= 8'h00;
      eng_phase        <= 0;
      busy_cnt         <= 0;
      str_cnt          <= 0;
      eng_byte         <= 8'h00;
    end else begin
      case (eng_phase)
        0: if (eng.o_mosi_valid && eng.i_mosi_ready) begin
          eng.i_mosi_ready <= 1'b0;
          eng_byte         <= eng.o_mosi_data;
          busy_cnt         <= int'($urandom_range(1, 3));
          eng_phase        <= 1;
        end
        1: if (busy_cnt > 1) begin
          busy_cnt <= busy_cnt - 1;
        end else begin
          eng.i_miso_valid <= 1'b1;
          eng.i_miso_data  <= eng_byte;
          str_cnt          <= stretch_cfg;
          if (stretch_cfg == 1) eng.i_mosi_ready <= 1'b1;
          eng_phase        <= 2;
        end
        default: if (str_cnt <= 1) begin
          eng.i_miso_valid <= 1'b0;
          eng_phase        <= 0;
        end else begin
          str_cnt <= str_cnt - 1;
          if (str_cnt == 2) eng.i_mosi_ready <= 1'b1;
        end
      endcase
    end
  end

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Reference arbitration rule: first requester at or after the pointer.
  function automatic int rr_winner(input logic [3:0] s, input int p);
    for (int i = 0; i < 4; i++) if (s[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic push_exp(input int k);
    exp_t e;
    e.k   = k;
    e.len = (i_req_len[4*k +: 4] == 4'd0) ? 16 : int'(i_req_len[4*k +: 4]);
    e.cfg = i_req_cfg[4*k +: 4];
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int k, input logic [3:0] len, input logic [3:0] cfg);
    i_req_len[4*k +: 4] = len;
    i_req_cfg[4*k +: 4] = cfg;
    for (int b = 0; b < 16; b++) plan_data[k][b] = 8'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
      i_req = 4'b0000;
    end
  endtask

  // hold_n == 0: each requester drops its request after its first byte.
  // hold_n > 0: requests stay high for hold_n grants.
  task automatic run_scenario(input string name, input logic [3:0] s, input int hold_n);
    int last = model_ptr;
    if (hold_n == 0) begin
      hold_mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (s[(model_ptr + i) % 4]) begin
          push_exp((model_ptr + i) % 4);
          last = (model_ptr + i) % 4;
        end
      end
      model_ptr = (last + 1) % 4;
    end else begin
      hold_mode = 1'b1;
      hold_left = hold_n;
      for (int n = 0; n < hold_n; n++) begin
        last = rr_winner(s, model_ptr);
        push_exp(last);
        model_ptr = (last + 1) % 4;
      end
    end
    i_req = s;
    wait_drain(name);
  endtask

  task automatic driver_loop();
    logic [3:0] prev_gnt = 4'b0000;
    int drv_k = 0;
    int drv_idx = 0;
    forever begin
      @(negedge clk);
      if (o_gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        drv_k   = oh_idx(o_gnt);
        drv_idx = 0;
      end
      prev_gnt   = o_gnt;
      i_tx_valid = 1'b0;
      if (o_tx_ready && $urandom_range(0, 3) != 0) begin
        i_tx_valid = 1'b1;
        i_tx_data  = plan_data[drv_k][drv_idx & 15];
        drv_idx++;
        if (drv_idx == 1) begin
          if (hold_mode) begin
            hold_left--;
            if (hold_left <= 0) i_req = 4'b0000;
          end else begin
            i_req[drv_k]           = 1'b0;
            i_req_len[4*drv_k +: 4] = 4'($urandom);
            i_req_cfg[4*drv_k +: 4] = 4'($urandom);
          end
        end
      end
    end
  endtask

  // Monitor: compares every MOSI byte, RX byte and done pulse to the queue head.
  initial begin
    exp_t e;
    int   tx_cnt = 0;
    int   rx_cnt = 0;
    forever begin
      @(negedge clk);
      if (mon_ignore || !rstn) begin
        tx_cnt = 0;
        rx_cnt = 0;
      end else begin
        if (eng.o_mosi_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mosi_unexpected: got=%02h gnt=%b required=no_byte", eng.o_mosi_data, o_gnt);
          end else begin
            e = exp_q[0];
            if (eng.o_mosi_data !== plan_data[e.k][tx_cnt & 15] || o_gnt !== 4'(1 << e.k)) begin
              errors++;
              $display("FAIL mosi_byte%0d: got=%02h gnt=%b required=%02h gnt=%b", tx_cnt,
                       eng.o_mosi_data, o_gnt, plan_data[e.k][tx_cnt & 15], 4'(1 << e.k));
            end
            tx_cnt++;
          end
        end
        if (o_rx_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got=%02h gnt=%b required=no_byte", o_rx_data, o_gnt);
          end else begin
            e = exp_q[0];
            if (o_rx_data !== plan_data[e.k][rx_cnt & 15] || o_gnt !== 4'(1 << e.k) ||
                {eng.o_cpol, eng.o_cpha, eng.o_cs} !== e.cfg) begin
              errors++;
              $display("FAIL rx_byte%0d: got=%02h gnt=%b cfg=%b required=%02h gnt=%b cfg=%b", rx_cnt,
                       o_rx_data, o_gnt, {eng.o_cpol, eng.o_cpha, eng.o_cs},
                       plan_data[e.k][rx_cnt & 15], 4'(1 << e.k), e.cfg);
            end
            rx_cnt++;
          end
        end
        if (o_done) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: gnt=%b required=no_done", o_gnt);
          end else begin
            e = exp_q.pop_front();
            if (o_gnt !== 4'(1 << e.k) || rx_cnt != e.len || tx_cnt != e.len) begin
              errors++;
              $display("FAIL txn_end: gnt=%b rx=%0d mosi=%0d required gnt=%b count=%0d",
                       o_gnt, rx_cnt, tx_cnt, 4'(1 << e.k), e.len);
            end else begin
              $display("txn gnt=%b bytes=%0d cfg=%b", o_gnt, rx_cnt, e.cfg);
            end
          end
          tx_cnt = 0;
          rx_cnt = 0;
        end
      end
    end
  end

  initial begin
    int mcount;
    int cyc;
    int bad;
    logic [27:0] outs;
    i_req      = 4'b0000;
    i_req_len  = 16'h0000;
    i_req_cfg  = 16'h0000;
    i_tx_data  = 8'h00;
    i_tx_valid = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 4'd1, 4'd0);
    fork
      driver_loop();
    join_none

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    outs = {o_gnt, o_tx_ready, o_rx_valid, o_done, eng.o_mosi_valid, eng.o_mosi_data,
            o_rx_data, eng.o_cpol, eng.o_cpha, eng.o_cs};
    checks++;
    if (outs !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got=%07h required=0000000", outs);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Single requester, two bytes, cpha=1 cs=2.
    stretch_cfg = 1;
    set_req(0, 4'd2, 4'b0110);
    plan_data[0][0] = 8'hA5;
    plan_data[0][1] = 8'h3C;
    run_scenario("single", 4'b0001, 0);

    // Fairness with all requests held.
    for (int k = 0; k < 4; k++) set_req(k, 4'd1, 4'($urandom));
    run_scenario("fair", 4'b1111, 5);

    // Zero length field means 16 bytes.
    set_req(1, 4'd0, 4'b1001);
    run_scenario("len16", 4'b0010, 0);

    // Stretched MISO valid.
    stretch_cfg = 3;
    set_req(3, 4'd3, 4'b1111);
    run_scenario("stretch", 4'b1000, 0);

    // Requester drops request after its first byte.
    stretch_cfg = 1;
    set_req(2, 4'd3, 4'b0011);
    run_scenario("drop", 4'b0100, 0);

    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) begin
        set_req(k, ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 5)), 4'($urandom));
      end
      stretch_cfg = int'($urandom_range(1, 3));
      run_scenario("random", 4'($urandom_range(1, 15)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : 0);
    end

    // Abort in WAIT_DONE of byte 2 of 4, after leaving the pointer at 3.
    mon_ignore  = 1'b1;
    hold_mode   = 1'b0;
    stretch_cfg = 1;
    set_req(2, 4'd4, 4'b1110);
    model_ptr = 3;
    i_req     = 4'b0100;
    mcount = 0;
    cyc    = 0;
    while (mcount < 2 && cyc < 2000) begin
      @(negedge clk);
      if (eng.o_mosi_valid) mcount++;
      cyc++;
    end
    checks++;
    if (mcount < 2) begin
      errors++;
      $display("FAIL abort_setup: mosi_pulses=%0d required=2", mcount);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    outs = {o_gnt, o_tx_ready, o_rx_valid, o_done, eng.o_mosi_valid, eng.o_mosi_data,
            o_rx_data, eng.o_cpol, eng.o_cpha, eng.o_cs};
    checks++;
    if (outs !== 28'd0) begin
      errors++;
      $display("FAIL abort_outputs: got=%07h required=0000000", outs);
    end
    rstn = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_gnt !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: active_cycles=%0d required=0", bad);
    end
    mon_ignore = 1'b0;
    model_ptr  = 0;
    for (int k = 0; k < 4; k++) set_req(k, 4'd1, 4'($urandom));
    run_scenario("post_reset", 4'b1111, 1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4: number of requesters, fixed at 4 in this revision.
REQ-002 Parameter LEN_W, 4: width of per-requester byte-count field.
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rstn  in  1  reset, synchronous, active-low.
REQ-005 i_req  in  4  per-requester transaction request, level.
REQ-006 i_req_len  in  16  packed 4x LEN_W byte count; requester k at [4k+3:4k]; 0 means 16 bytes.
REQ-007 i_req_cfg  in  16  packed 4x {cpol, cpha, cs[1:0]}; requester k at [4k+3:4k].
REQ-008 o_gnt  out  4  one-hot grant, held for the whole transaction.
REQ-009 i_tx_data  in  8  byte from the granted requester.
REQ-010 i_tx_valid / o_tx_ready  in/out  1  valid/ready; byte accepted when both are high.
REQ-011 o_rx_data  out  8  received byte; o_rx_valid  out  1  one-cycle strobe, owner is o_gnt.
REQ-012 o_done  out  1  one-cycle pulse after the last byte of a transaction; o_gnt is still valid in that cycle.
REQ-013 o_mosi_data  out  8, o_mosi_valid  out  1: byte port to the SPI byte engine.
REQ-014 i_mosi_ready  in  1: engine idle; i_miso_valid  in  1, i_miso_data  in  8: engine receive port.
REQ-015 o_cpol, o_cpha  out  1 each; o_cs  out  2: engine configuration.

Function
REQ-016 States: IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE, DONE.
REQ-017 IDLE: when any i_req is high and i_mosi_ready=1, grant the winner by round-robin.
- Winner is the first requester at or after the pointer; pointer resets to 0.
- After granting k, the pointer moves to (k+1) mod 4.
- o_gnt, the length counter and the config are registered in the same cycle; next state is LOAD.
REQ-018 o_cpol/o_cpha/o_cs are latched from the winner's i_req_cfg at grant and held constant until the next grant.
REQ-019 LOAD: o_tx_ready=1; on i_tx_valid, latch i_tx_data into o_mosi_data and go to SEND; otherwise wait indefinitely.
REQ-020 SEND: o_mosi_valid=1 for exactly one cycle; o_mosi_data is held stable from SEND until the next LOAD accept; next state is WAIT_BUSY.
REQ-021 WAIT_BUSY: stay until i_mosi_ready=0, then go to WAIT_DONE.
REQ-022 WAIT_DONE:
- A rising edge of i_miso_valid (registered previous value was 0, current is 1) captures i_miso_data into o_rx_data and pulses o_rx_valid once.
- Leave only when the byte has been captured and i_mosi_ready=1.
REQ-023 On leaving WAIT_DONE, decrement the remaining count.
- If the count was 1 (or 16 wrapped to 0 and finished), go to DONE.
- Otherwise go to LOAD.
REQ-024 DONE: pulse o_done, clear o_gnt, return to IDLE; a new grant can occur no earlier than the following cycle.
REQ-025 Deasserting i_req mid-transaction is ignored: the transaction runs to its full length.
REQ-026 Changes to i_req_len and i_req_cfg after grant are ignored.
REQ-027 Exactly one o_rx_valid per byte sent; extra i_miso_valid high cycles within one byte are ignored.
REQ-028 o_tx_ready is high only in LOAD; o_gnt is zero in IDLE.

Reset
REQ-029 With i_rstn=0 at a clock edge:
- state=IDLE, pointer=0.
- o_gnt, o_tx_ready, o_rx_valid, o_done, o_mosi_valid, o_mosi_data, o_rx_data, o_cpol, o_cpha = 0; o_cs = 0.
- Applies also mid-transaction; the aborted transaction gives no o_done.

Structure
REQ-030 Package spi_ctrl_pkg holds: the state encoding, NUM_REQ, LEN_W, and the cfg field offsets (CPOL=3, CPHA=2, CS=1:0).
REQ-031 Round-robin selection sits in sub-module spi_rr_arbiter: request vector plus pointer in, one-hot grant out, purely combinational.

Verification
REQ-032 Single requester: i_req=0001, len=2, cfg=4'b0110, tx bytes A5 and 3C, engine model loops MOSI back to MISO -> o_cpha=1, o_cs=2, two o_rx_valid with A5 then 3C, one o_done, o_gnt=0001 throughout.
REQ-033 Fairness: i_req=1111 held, all len=1 -> grant order 0001, 0010, 0100, 1000, 0001, each followed by one o_done.
REQ-034 Length 0: len=0 -> exactly 16 SEND pulses and 16 o_rx_valid before o_done.
REQ-035 Stretched miso: engine holds i_miso_valid high 3 cycles per byte, len=3 -> exactly 3 o_rx_valid.
REQ-036 Reset mid-transaction: i_rstn=0 in WAIT_DONE of byte 2 of 4 -> next cycle all outputs 0, no o_done, next grant goes to requester 0.
REQ-037 Requester 2 drops i_req after the first byte of len=3 -> all 3 bytes still transferred, then o_done.
